// File: rtl/ser_frame_collector.sv
// ---------------------------------------------------------------------------
// ser_frame_collector
//
// Purpose:
//   Collects the recovered serial stream into bytes, most significant bit
//   first, and buffers the completed bytes in a small FIFO. The host reads
//   the FIFO through a valid/ready handshake. The block also reports, for
//   each frame, how many whole bytes it collected and whether the frame
//   finished normally, was aborted, or lost bytes because the FIFO was full.
//
// Parameters:
//   DEPTH    FIFO entries (power of two, >= 2)
//   COUNT_W  width of byteCount; the count saturates at all-ones
//
// Ports:
//   clk           single clock, all state updates on the rising edge
//   rst           asynchronous, active-high reset
//   txOut         serial data bit, used when txValid is high
//   txValid       txOut carries a payload bit this cycle
//   txAbort       upstream abort pulse; takes priority over txValid
//   rdReady       host takes rdData this cycle
//   rdData        FIFO head byte, 8'h00 while the FIFO is empty
//   rdValid       FIFO holds at least one byte
//   byteCount     whole bytes collected in the current or last frame
//   frameDone     one-cycle pulse after a frame ends normally
//   frameAborted  one-cycle pulse after an abort
//   overflow      sticky flag: a completed byte was dropped on a full FIFO
// ---------------------------------------------------------------------------
module ser_frame_collector #(
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               txOut,
  input  logic               txValid,
  input  logic               txAbort,
  input  logic               rdReady,
  output logic [7:0]         rdData,
  output logic               rdValid,
  output logic [COUNT_W-1:0] byteCount,
  output logic               frameDone,
  output logic               frameAborted,
  output logic               overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t state;
  state_t state_next;

  // Frame control strobes decoded from the FSM
  logic shift_bit;
  logic start_frame;
  logic end_frame;
  logic abort_frame;

  // Bit assembly
  logic [6:0] sr;
  logic [2:0] bit_cnt;
  logic       push;
  logic [7:0] push_byte;

  // FIFO storage and bookkeeping
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] level;
  logic             full;
  logic             pop;
  logic             write;

  // State register for the frame FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: an abort wins over everything else and returns to IDLE
  // from either state; a drop of txValid while receiving ends the frame.
  always_comb begin
    state_next  = state;
    shift_bit   = 1'b0;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    abort_frame = 1'b0;
    if (txAbort) begin
      abort_frame = 1'b1;
      state_next  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (txValid) begin
            shift_bit   = 1'b1;
            start_frame = 1'b1;
            state_next  = RECV;
          end
        end
        RECV: begin
          if (txValid) begin
            shift_bit = 1'b1;
          end else begin
            end_frame  = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // The eighth bit of a byte completes it combinationally so that it is
  // written into the FIFO on the same edge it is sampled.
  assign push      = shift_bit && (bit_cnt == 3'd7);
  assign push_byte = {sr, txOut};

  // Shift register, bit counter, byte counter and status pulses. Residual
  // bits of an incomplete byte are thrown away when the frame ends so that
  // the next frame always starts byte-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr           <= '0;
      bit_cnt      <= '0;
      byteCount    <= '0;
      frameDone    <= 1'b0;
      frameAborted <= 1'b0;
    end else begin
      frameDone    <= end_frame;
      frameAborted <= abort_frame;
      if (abort_frame) begin
        sr        <= '0;
        bit_cnt   <= '0;
        byteCount <= '0;
      end else if (shift_bit) begin
        sr      <= push_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (start_frame) begin
          byteCount <= '0;
        end else if (push && (byteCount != '1)) begin
          byteCount <= byteCount + COUNT_W'(1);
        end
      end else if (end_frame) begin
        sr      <= '0;
        bit_cnt <= '0;
      end
    end
  end

  // A pop in the same cycle frees a slot, so a push onto a full FIFO is only
  // lost when the host is not reading at the same time.
  assign full    = (level == FULL_LEVEL);
  assign rdValid = (level != '0);
  assign pop     = rdValid && rdReady;
  assign write   = push && (!full || pop);
  assign rdData  = rdValid ? mem[rd_ptr] : 8'h00;

  // FIFO pointers, fill level, storage and the sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      if (write) begin
        mem[wr_ptr] <= push_byte;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (write && !pop) begin
        level <= level + CNT_W'(1);
      end else if (pop && !write) begin
        level <= level - CNT_W'(1);
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
